// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side framing stage.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 2;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Error causes reported on err_code
  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_LEN     = 2'd1;
  localparam logic [ERR_W-1:0] ERR_CHK     = 2'd2;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-receiver input and verified payload output of the frame parser.
interface uart_frame_parser_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_done;
  logic              frame_err;
  logic [ERR_W-1:0]  err_code;
  logic              busy;

  // Parser side
  modport slave (
    input  rx_data, rx_ready, out_ready,
    output out_data, out_valid, frame_done, frame_err, err_code, busy
  );

  // Receiver / sink side
  modport master (
    output rx_data, rx_ready, out_ready,
    input  out_data, out_valid, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload buffer: register array, synchronous write, asynchronous read, no reset.
module frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF, LEN, payload[LEN], CHK -> verified valid/ready byte stream.
// Optional CHK byte and running sum are built only when UART_FRAME_CHECKSUM_EN
// is defined; otherwise the frame ends with its last payload byte.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned       MAX_LEN = 16,
  parameter logic [BYTE_W-1:0] SOF     = SOF_DEFAULT,
  parameter int unsigned       TIMEOUT = 104160
) (
  input logic               clk,
  input logic               rst,
  uart_frame_parser_if.slave bus
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e            r_state;
  state_e            w_state_next;

  logic              r_rdy_d;
  logic              w_byte_stb;
  logic [BYTE_W-1:0] w_byte;

  logic [BYTE_W-1:0] r_len;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
`endif

  logic              r_out_valid;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_frame_err;
  logic [ERR_W-1:0]  r_err_code;
  logic              r_busy;

  logic              w_err;
  logic [ERR_W-1:0]  w_err_code;
  logic              w_len_load;
  logic              w_wr_en;
  logic              w_drain_enter;
  logic              w_hs;
  logic              w_last;
  logic              w_done;
  logic              w_to;
  logic              w_cnt_run;

  logic [AW-1:0]     w_raddr;
  logic [BYTE_W-1:0] w_rdata;
  logic [BYTE_W-1:0] w_rdata_fwd;

  assign w_byte     = bus.rx_data;
  assign w_byte_stb = bus.rx_ready & ~r_rdy_d;
  assign w_hs       = r_out_valid & bus.out_ready;
  assign w_last     = (BYTE_W'(r_rd_ptr) == (r_len - 8'd1));
  assign w_cnt_run  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
  assign w_to       = w_cnt_run && (r_cnt == CW'(TIMEOUT - 1)) && !w_byte_stb;

  // Next read address: slot 0 when a drain starts, otherwise the byte after the accepted one
  assign w_raddr     = (r_state == ST_DRAIN) ? AW'(r_rd_ptr + PW'(1)) : '0;
  // A one-byte frame without CHK enters DRAIN while its only byte is still being written
  assign w_rdata_fwd = (w_wr_en && (AW'(r_wr_ptr) == w_raddr)) ? w_byte : w_rdata;

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (AW'(r_wr_ptr)),
    .wdata (w_byte),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    w_state_next  = r_state;
    w_err         = 1'b0;
    w_err_code    = ERR_NONE;
    w_len_load    = 1'b0;
    w_wr_en       = 1'b0;
    w_drain_enter = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_byte_stb && (w_byte == SOF)) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_byte_stb) begin
          if ((w_byte == 8'd0) || (w_byte > BYTE_W'(MAX_LEN))) begin
            w_err        = 1'b1;
            w_err_code   = ERR_LEN;
            w_state_next = ST_IDLE;
          end else begin
            w_len_load   = 1'b1;
            w_state_next = ST_PAYLOAD;
          end
        end else if (w_to) begin
          w_err        = 1'b1;
          w_err_code   = ERR_TIMEOUT;
          w_state_next = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (w_byte_stb) begin
          w_wr_en = 1'b1;
          if ((BYTE_W'(r_wr_ptr) + 8'd1) == r_len) begin
`ifdef UART_FRAME_CHECKSUM_EN
            w_state_next  = ST_CHK;
`else
            w_state_next  = ST_DRAIN;
            w_drain_enter = 1'b1;
`endif
          end
        end else if (w_to) begin
          w_err        = 1'b1;
          w_err_code   = ERR_TIMEOUT;
          w_state_next = ST_IDLE;
        end
      end
      ST_CHK: begin
`ifdef UART_FRAME_CHECKSUM_EN
        if (w_byte_stb) begin
          if (w_byte == r_sum) begin
            w_state_next  = ST_DRAIN;
            w_drain_enter = 1'b1;
          end else begin
            w_err        = 1'b1;
            w_err_code   = ERR_CHK;
            w_state_next = ST_IDLE;
          end
        end else if (w_to) begin
          w_err        = 1'b1;
          w_err_code   = ERR_TIMEOUT;
          w_state_next = ST_IDLE;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_DRAIN: begin
        // Incoming bytes are ignored until the buffered frame has been delivered
        if (w_hs && w_last) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Inter-byte timeout counter, live only while a frame is being received
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_cnt <= '0;
    else if (w_byte_stb || !w_cnt_run) r_cnt <= '0;
    else                             r_cnt <= r_cnt + CW'(1);
  end

  // Datapath: strobe edge detect, length, pointers, checksum and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_d     <= 1'b1;
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_sum       <= '0;
`endif
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_rdy_d     <= bus.rx_ready;
      r_frame_err <= w_err;
      r_busy      <= (w_state_next != ST_IDLE);
      if (w_err) begin
        r_err_code <= w_err_code;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end
      if (w_len_load) begin
        r_len    <= w_byte;
        r_wr_ptr <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
        r_sum    <= w_byte;
`endif
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
        r_sum    <= r_sum + w_byte;
`endif
      end
      if (w_drain_enter) begin
        r_out_valid <= 1'b1;
        r_rd_ptr    <= '0;
        r_out_data  <= w_rdata_fwd;
      end else if (w_hs) begin
        if (w_last) begin
          r_out_valid <= 1'b0;
          r_rd_ptr    <= '0;
          r_wr_ptr    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
          r_sum       <= '0;
`endif
        end else begin
          r_rd_ptr   <= r_rd_ptr + PW'(1);
          r_out_data <= w_rdata_fwd;
        end
      end
    end
  end

  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.frame_done = w_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.err_code   = r_err_code;
  assign bus.busy       = r_busy;

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Receive-side framing stage placed directly downstream of the UART byte receiver. It consumes the receiver's byte output (`rx_data` / `rx_ready`) and assembles frames of the form SOF, LEN, payload[LEN], CHK. It buffers the payload and releases it on a valid/ready byte stream only after the frame is verified. Malformed, corrupt or stalled frames are discarded and reported.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes; buffer depth. Power of two, 2..64.
- `SOF`, 8'h55: start-of-frame byte value.
- `TIMEOUT`, 104160: inter-byte timeout in clk cycles (about two byte times at 5208 clk/bit).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: received byte. Valid while `rx_ready` is high.
- `rx_ready`  in  1: level, high for the receiver's stop-bit interval (many clk cycles) per byte.
- `out_data`  out  8: payload byte at the read pointer.
- `out_valid`  out  1: payload byte available.
- `out_ready`  in  1: sink accepts the byte.
- `frame_done`  out  1: one-cycle pulse when the last payload byte of a good frame is accepted.
- `frame_err`  out  1: one-cycle pulse when a frame is discarded.
- `err_code`  out  2: cause of the last error, held until the next error. 1 = bad LEN, 2 = bad CHK, 3 = timeout. 0 only after reset.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Byte strobe:
  - `rx_ready` is registered into `rdy_d`.
  - `byte_stb = rx_ready & ~rdy_d`, exactly one cycle per byte.
  - `rx_data` is sampled in the `byte_stb` cycle.
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN.
  - IDLE:
    - Byte == SOF → LEN.
    - Any other byte is silently dropped.
  - LEN:
    - Byte 0 or byte > MAX_LEN → error code 1, go to IDLE.
    - Otherwise store `len`, set `sum = byte`, clear `wr_ptr`, go to PAYLOAD.
  - PAYLOAD:
    - Each byte is written to `buf[wr_ptr]`; `wr_ptr++`; `sum += byte` (8-bit, wraps mod 256).
    - After the `len`-th byte → CHK.
  - CHK:
    - Byte == `sum` → DRAIN with `rd_ptr = 0`.
    - Otherwise error code 2, go to IDLE.
  - DRAIN:
    - `out_valid = 1`, `out_data = buf[rd_ptr]`.
    - On `out_valid & out_ready`: `rd_ptr++`.
    - On acceptance of byte `len-1`: pulse `frame_done`, go to IDLE.
    - `byte_stb` arriving in DRAIN is dropped with no error, including SOF.
- Timeout:
  - A counter clears on every `byte_stb` and on entry to LEN.
  - It counts in LEN, PAYLOAD and CHK.
  - Reaching TIMEOUT-1 → error code 3, go to IDLE. The counter is not active in IDLE or DRAIN.
- Error action: pulse `frame_err`, update `err_code`, clear pointers and `sum` in the same cycle as the transition to IDLE.
- Width rules:
  - `wr_ptr`/`rd_ptr` are $clog2(MAX_LEN)+1 bits.
  - `len` is 8 bits.
  - The timeout counter is $clog2(TIMEOUT) bits.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid` 0, `out_data` 0, `frame_done` 0, `frame_err` 0, `err_code` 0, `busy` 0.
  - `rdy_d` 1, so an `rx_ready` held high through reset release does not produce a strobe.
- `byte_stb` occurs one cycle after `rx_ready` rises.
- State updates on the clock edge ending the `byte_stb` cycle.
- `out_valid` rises the cycle after the CHK byte strobe.
- Output throughput is one byte per cycle when `out_ready` is held high.
- `out_data` is stable while `out_valid & ~out_ready`.
- `frame_done` is asserted in the same cycle as the final accepting handshake. `out_valid` is 0 in the next cycle.
- `frame_err` is asserted in the cycle following the offending strobe or timeout expiry.
- Reset mid-frame or mid-drain discards everything. No pulses are emitted.

## Configuration
- `UART_FRAME_CHECKSUM_EN`:
  - Defined: the frame carries a CHK byte and the CHK state is present as described above.
  - Undefined: the CHK state and `sum` are removed. After the `len`-th payload byte the parser enters DRAIN directly, and `err_code` 2 is never produced.

## Structure
- Shared package `uart_pkg`:
  - State enum.
  - Error code constants `ERR_NONE`, `ERR_LEN`, `ERR_CHK`, `ERR_TIMEOUT`.
  - Default SOF.
- Sub-module `frame_buf`:
  - MAX_LEN x 8 register array.
  - Synchronous write port (`we`, `waddr`, `wdata`).
  - Asynchronous read port (`raddr` → `rdata`).
  - No reset on contents.
- The FSM, counters and checksum live in `uart_frame_parser`.

## Test plan
- Good frame: bytes 55 03 11 22 33 69 with `out_ready` = 1.
  - Expect `out_data` 11, 22, 33 on consecutive cycles.
  - `frame_done` pulses once with 33; `frame_err` stays 0.
- Backpressure: same frame with `out_ready` toggling 1010….
  - Same three bytes in order; `out_data` is held during stalls.
- Bad checksum: 55 02 AA BB 00.
  - `frame_err` pulses, `err_code` = 2, `out_valid` never asserts.
  - A following good frame 55 01 07 08 outputs 07.
- Bad length and noise: bytes 00 FF 55 00.
  - The first two bytes are dropped silently; `err_code` = 1.
  - Repeat with LEN = 17 → `err_code` = 1.
- Timeout: send 55 02 10, then stay idle for TIMEOUT cycles.
  - `frame_err` pulses with `err_code` = 3, `busy` = 0.
  - The next good frame is received normally.
- Reset and drain overlap:
  - Assert `rst` mid-payload → all outputs return to reset values.
  - A SOF arriving during DRAIN is ignored and does not corrupt the current output.
